// File: rtl/bg_pkg.sv
// Shared scan codes and state encodings for the background selector.
// Used by bg_select_controller and ps2_event_decoder.
package bg_pkg;

    localparam logic [7:0] KEY_B     = 8'h32;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        MAIN_IDLE,
        MAIN_MENU,
        MAIN_PENDING
    } main_state_e;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_e;

endpackage

// File: rtl/ps2_event_decoder.sv
// PS/2 prefix decoder: folds E0/F0 prefixes into make events.
// Events are combinational so they act on the same edge they decode.
module ps2_event_decoder
    import bg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       key_pressed_i,
    input  logic [7:0] key_data_i,
    output logic       ev_valid_o,
    output logic       ev_ext_o,
    output logic [7:0] ev_code_o
);

    dec_state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= DEC_NORMAL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ev_valid_o = 1'b0;
        ev_ext_o   = 1'b0;
        ev_code_o  = key_data_i;
        if (key_pressed_i) begin
            case (state_q)
                DEC_NORMAL: begin
                    if (key_data_i == PS2_EXT)      state_d = DEC_EXT;
                    else if (key_data_i == PS2_BRK) state_d = DEC_BRK;
                    else                            ev_valid_o = 1'b1;
                end
                DEC_EXT: begin
                    if (key_data_i == PS2_BRK) begin
                        state_d = DEC_EXT_BRK;
                    end else begin
                        ev_valid_o = 1'b1;
                        ev_ext_o   = 1'b1;
                        state_d    = DEC_NORMAL;
                    end
                end
                default: state_d = DEC_NORMAL;
            endcase
        end
    end

endmodule

// File: rtl/bg_select_controller.sv
// Background menu FSM; commits the chosen index on a vsync boundary.
// Optional frame-based auto-advance in IDLE under BG_AUTOCYCLE_EN.
module bg_select_controller
    import bg_pkg::*;
#(
    parameter int NUM_BG       = 5,
    parameter int RESET_BG     = 0,
    parameter int CYCLE_FRAMES = 600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_key_data,
    input  logic        vsync_start,
    input  logic        game_running,
    output logic [31:0] background_out,
    output logic [31:0] preview_index,
    output logic        menu_active,
    output logic        bg_changed
);

    localparam int IW = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
    localparam logic [IW-1:0] LAST    = IW'(NUM_BG - 1);
    localparam logic [IW-1:0] RST_IDX = IW'(RESET_BG);

    logic       ev_valid, ev_ext;
    logic [7:0] ev_code;

    ps2_event_decoder u_dec (
        .clock         (clock),
        .reset         (reset),
        .key_pressed_i (ps2_key_pressed),
        .key_data_i    (ps2_key_data),
        .ev_valid_o    (ev_valid),
        .ev_ext_o      (ev_ext),
        .ev_code_o     (ev_code)
    );

    logic key_b, key_enter, key_esc, key_left, key_right;
    assign key_b     = ev_valid && !ev_ext && (ev_code == KEY_B);
    assign key_enter = ev_valid && !ev_ext && (ev_code == KEY_ENTER);
    assign key_esc   = ev_valid && !ev_ext && (ev_code == KEY_ESC);
    assign key_left  = ev_valid &&  ev_ext && (ev_code == KEY_LEFT);
    assign key_right = ev_valid &&  ev_ext && (ev_code == KEY_RIGHT);

    main_state_e   state_q, state_d;
    logic [IW-1:0] bg_q, bg_d;
    logic [IW-1:0] prev_q, prev_d;
    logic          chg_q, chg_d;
    logic [IW-1:0] prev_inc, prev_dec;

    assign prev_inc = (prev_q == LAST) ? '0 : prev_q + IW'(1);
    assign prev_dec = (prev_q == '0) ? LAST : prev_q - IW'(1);

`ifdef BG_AUTOCYCLE_EN
    localparam int CW = $clog2(CYCLE_FRAMES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MAIN_IDLE;
            bg_q    <= RST_IDX;
            prev_q  <= RST_IDX;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bg_q    <= bg_d;
            prev_q  <= prev_d;
            chg_q   <= chg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bg_d    = bg_q;
        prev_d  = prev_q;
        chg_d   = 1'b0;
        case (state_q)
            MAIN_IDLE: begin
                if (key_b && !game_running) begin
                    state_d = MAIN_MENU;
                    prev_d  = bg_q;
                end
            end
            MAIN_MENU: begin
                // A round starting cancels the menu even if a key lands too
                if (game_running || key_esc || key_b) begin
                    state_d = MAIN_IDLE;
                    prev_d  = bg_q;
                end else if (key_right) begin
                    prev_d = prev_inc;
                end else if (key_left) begin
                    prev_d = prev_dec;
                end else if (key_enter) begin
                    state_d = MAIN_PENDING;
                end
            end
            MAIN_PENDING: begin
                if (vsync_start) begin
                    bg_d    = prev_q;
                    chg_d   = 1'b1;
                    state_d = MAIN_IDLE;
                end
            end
            default: state_d = MAIN_IDLE;
        endcase
`ifdef BG_AUTOCYCLE_EN
        cnt_d = cnt_q;
        if (state_q != MAIN_IDLE || game_running || ev_valid) begin
            cnt_d = '0;
        end else if (vsync_start) begin
            if (cnt_q == CW'(CYCLE_FRAMES - 1)) begin
                cnt_d = '0;
                bg_d  = (bg_q == LAST) ? '0 : bg_q + IW'(1);
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    assign background_out = 32'(bg_q);
    assign preview_index  = 32'(prev_q);
    assign menu_active    = (state_q == MAIN_MENU);
    assign bg_changed     = chg_q;

endmodule

// File: tb/tb_bg_select_controller.sv
// Directed scoreboard bench for bg_select_controller.
// Build with BG_AUTOCYCLE_EN to cover the auto-advance path.
module tb_bg_select_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_key_pressed = 1'b0;
    logic [7:0]  ps2_key_data = 8'h00;
    logic        vsync_start = 1'b0;
    logic        game_running = 1'b0;
    logic [31:0] background_out;
    logic [31:0] preview_index;
    logic        menu_active;
    logic        bg_changed;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef BG_AUTOCYCLE_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    typedef struct {
        string       tag;
        logic [65:0] v;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    bg_select_controller #(
        .NUM_BG       (5),
        .RESET_BG     (0),
        .CYCLE_FRAMES (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .vsync_start     (vsync_start),
        .game_running    (game_running),
        .background_out  (background_out),
        .preview_index   (preview_index),
        .menu_active     (menu_active),
        .bg_changed      (bg_changed)
    );

    task automatic push_exp(input string tag, input int bg, input int pv,
                            input logic m, input logic c);
        exp_t e;
        e.tag = tag;
        e.v   = {32'(bg), 32'(pv), m, c};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [65:0] obs;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed none expected entry");
            return;
        end
        e   = sb.pop_front();
        obs = {background_out, preview_index, menu_active, bg_changed};
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed bg=%0d prev=%0d menu=%0b chg=%0b expected bg=%0d prev=%0d menu=%0b chg=%0b",
                   e.tag, obs[65:34], obs[33:2], obs[1], obs[0],
                   e.v[65:34], e.v[33:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic st(input logic kp, input logic [7:0] d, input logic vs,
                      input string tag, input int bg, input int pv,
                      input logic m, input logic c);
        ps2_key_pressed = kp;
        ps2_key_data    = d;
        vsync_start     = vs;
        push_exp(tag, bg, pv, m, c);
        @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        vsync_start     = 1'b0;
        check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        push_exp("reset", 0, 0, 1'b0, 1'b0);
        check();
        @(negedge clock);
        reset = 1'b0;

        st(1, 8'h32, 0, "open", 0, 0, 1, 0);
        st(1, 8'hE0, 0, "e0_a", 0, 0, 1, 0);
        st(1, 8'h74, 0, "right1", 0, 1, 1, 0);
        st(1, 8'hE0, 0, "e0_b", 0, 1, 1, 0);
        st(1, 8'h74, 0, "right2", 0, 2, 1, 0);
        st(1, 8'h5A, 0, "enter", 0, 2, 0, 0);
        st(0, 8'h00, 0, "pend_wait", 0, 2, 0, 0);
        st(0, 8'h00, 1, "commit", 2, 2, 0, 1);
        st(0, 8'h00, 0, "post_commit", 2, 2, 0, 0);

        st(1, 8'h32, 0, "open2", 2, 2, 1, 0);
        st(1, 8'hE0, 0, "e0_c", 2, 2, 1, 0);
        st(1, 8'h6B, 0, "left1", 2, 1, 1, 0);
        st(1, 8'hE0, 0, "e0_d", 2, 1, 1, 0);
        st(1, 8'h6B, 0, "left0", 2, 0, 1, 0);
        st(1, 8'hE0, 0, "e0_e", 2, 0, 1, 0);
        st(1, 8'h6B, 0, "wrap_left", 2, 4, 1, 0);
        st(1, 8'hE0, 0, "e0_f", 2, 4, 1, 0);
        st(1, 8'h74, 0, "wrap_right", 2, 0, 1, 0);
        st(1, 8'h76, 0, "esc", 2, 2, 0, 0);

        st(1, 8'h32, 0, "open3", 2, 2, 1, 0);
        st(1, 8'hF0, 0, "brk_prefix", 2, 2, 1, 0);
        st(1, 8'h32, 0, "break_b", 2, 2, 1, 0);
        st(1, 8'h76, 0, "esc2", 2, 2, 0, 0);

        st(1, 8'h32, 0, "open4", 2, 2, 1, 0);
        st(1, 8'hE0, 0, "e0_g", 2, 2, 1, 0);
        st(1, 8'h74, 0, "right3", 2, 3, 1, 0);
        st(1, 8'hE0, 0, "e0_h", 2, 3, 1, 0);
        game_running = 1'b1;
        st(1, 8'h74, 0, "gr_cancel", 2, 2, 0, 0);
        st(1, 8'h32, 0, "b_running", 2, 2, 0, 0);
        game_running = 1'b0;

        st(1, 8'h32, 0, "open5", 2, 2, 1, 0);
        st(1, 8'hE0, 0, "e0_i", 2, 2, 1, 0);
        st(1, 8'h74, 0, "right4", 2, 3, 1, 0);
        st(1, 8'h5A, 1, "enter_vsync", 2, 3, 0, 0);
        st(0, 8'h00, 0, "pend_hold", 2, 3, 0, 0);
        st(1, 8'hE0, 0, "pend_e0", 2, 3, 0, 0);
        st(1, 8'h74, 0, "pend_key", 2, 3, 0, 0);
        game_running = 1'b1;
        st(0, 8'h00, 1, "commit_gr", 3, 3, 0, 1);
        game_running = 1'b0;
        st(0, 8'h00, 0, "idle3", 3, 3, 0, 0);

        st(1, 8'h32, 0, "open6", 3, 3, 1, 0);
        st(1, 8'h5A, 0, "enter_same", 3, 3, 0, 0);
        st(0, 8'h00, 1, "same_idx", 3, 3, 0, 1);

        st(1, 8'h32, 0, "open7", 3, 3, 1, 0);
        st(1, 8'hE0, 0, "e0_j", 3, 3, 1, 0);
        st(1, 8'h74, 0, "right5", 3, 4, 1, 0);
        st(1, 8'h5A, 0, "enter7", 3, 4, 0, 0);
        reset = 1'b1;
        #1;
        push_exp("async_rst", 0, 0, 1'b0, 1'b0);
        check();
        @(negedge clock);
        reset = 1'b0;

        st(0, 8'h00, 1, "auto_v1", 0, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v2", 0, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v3", AUTO, 0, 0, 1'(AUTO));
        st(0, 8'h00, 0, "auto_idle", AUTO, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v4", AUTO, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v5", AUTO, 0, 0, 0);
        st(1, 8'h1C, 0, "auto_key", AUTO, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v6", AUTO, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v7", AUTO, 0, 0, 0);
        st(0, 8'h00, 1, "auto_v8", 2 * AUTO, 0, 0, 1'(AUTO));
        st(0, 8'h00, 0, "auto_end", 2 * AUTO, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
